// File: rtl/axi_lite_timer.sv
// AXI4-Lite down-counting timer: one-shot or periodic expiry, sticky pending flag, level interrupt.
// Single-beat slave; one write and one read may be in flight independently.
module axi_lite_timer #(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        interrupt
);
  localparam logic [31:0] VERSION = 32'h2024_0100;

  logic        en_q, en_d, ie_q, ie_d, per_q, per_d, pend_q, pend_d;
  logic [31:0] period_q, period_d, count_q, count_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_acc, rd_acc, expire, clr;
  logic [31:0] rd_val;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{s_axi_awaddr[31:5], s_axi_awaddr[1:0],
                              s_axi_araddr[31:5], s_axi_araddr[1:0]};

  assign wr_acc        = s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
  assign rd_acc        = s_axi_arvalid & ~rvalid_q;
  assign s_axi_awready = wr_acc;
  assign s_axi_wready  = wr_acc;
  assign s_axi_arready = rd_acc;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign interrupt     = pend_q & ie_q;
  assign expire        = en_q & (count_q == 32'd0);

  always_comb begin
    rd_val = 32'd0;
    case (s_axi_araddr[4:2])
      3'd0:    rd_val = {29'd0, per_q, ie_q, en_q};
      3'd1:    rd_val = {31'd0, pend_q};
      3'd2:    rd_val = period_q;
      3'd3:    rd_val = count_q;
      3'd4:    rd_val = 32'(CLK_FREQ);
      3'd5:    rd_val = VERSION;
      default: rd_val = 32'd0;
    endcase
  end

  always_comb begin
    en_d     = en_q;
    ie_d     = ie_q;
    per_d    = per_q;
    period_d = period_q;
    count_d  = count_q;
    clr      = 1'b0;

    if (en_q) begin
      if (expire) begin
        if (per_q) count_d = period_q;
        else       en_d    = 1'b0;
      end else begin
        count_d = count_q - 32'd1;
      end
    end

    // A CONTROL write overrides the tick: en=0 freezes COUNT at its pre-edge
    // value, and only a 0->1 transition of en reloads.
    if (wr_acc) begin
      case (s_axi_awaddr[4:2])
        3'd0: begin
          en_d  = s_axi_wdata[0];
          ie_d  = s_axi_wdata[1];
          per_d = s_axi_wdata[2];
          if (!s_axi_wdata[0])  count_d = count_q;
          else if (!en_q)       count_d = period_q;
        end
        3'd1:    clr      = s_axi_wdata[0];
        3'd2:    period_d = s_axi_wdata;
        default: ;
      endcase
    end

    pend_d   = expire | (pend_q & ~clr);
    bvalid_d = wr_acc | (bvalid_q & ~s_axi_bready);
    rvalid_d = rd_acc | (rvalid_q & ~s_axi_rready);
    rdata_d  = rd_acc ? rd_val : rdata_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      per_q    <= 1'b0;
      pend_q   <= 1'b0;
      period_q <= 32'd0;
      count_q  <= 32'd0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      en_q     <= en_d;
      ie_q     <= ie_d;
      per_q    <= per_d;
      pend_q   <= pend_d;
      period_q <= period_d;
      count_q  <= count_d;
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_timer.sv
// Bench for axi_lite_timer: directed scenarios plus random register traffic, all
// checked every cycle against a behavioural model of the register file and timer.
module tb_axi_lite_timer;
  logic        aclk = 1'b0, areset = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int nchk = 0, nfail = 0, cyc = 0;

  axi_lite_timer #(.CLK_FREQ(100_000_000)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .interrupt(irq)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        en, ie, per, pend;
    logic [31:0] period, count;
    logic        bvalid, rvalid;
    logic [31:0] rdata;
  } mdl_t;

  mdl_t m = '0;

  function automatic logic [31:0] reg_val(mdl_t s, logic [31:0] a);
    case (a[4:2])
      3'd0:    return {29'd0, s.per, s.ie, s.en};
      3'd1:    return {31'd0, s.pend};
      3'd2:    return s.period;
      3'd3:    return s.count;
      3'd4:    return 32'd100_000_000;
      3'd5:    return 32'h2024_0100;
      default: return 32'd0;
    endcase
  endfunction

  function automatic mdl_t step(mdl_t s);
    mdl_t n;
    logic wacc, fire, clear;
    n     = s;
    wacc  = awvalid && wvalid && !s.bvalid;
    fire  = s.en && (s.count == 0);
    clear = 1'b0;
    if (fire) begin
      n.count = s.per ? s.period : 32'd0;
      if (!s.per) n.en = 1'b0;
    end else if (s.en) begin
      n.count = s.count - 1;
    end
    if (wacc) begin
      if (awaddr[4:2] == 3'd0) begin
        {n.per, n.ie, n.en} = wdata[2:0];
        if (wdata[0] == 1'b0)  n.count = s.count;
        else if (!s.en)        n.count = s.period;
      end else if (awaddr[4:2] == 3'd1) begin
        clear = wdata[0];
      end else if (awaddr[4:2] == 3'd2) begin
        n.period = wdata;
      end
    end
    n.pend   = fire || (s.pend && !clear);
    n.bvalid = wacc || (s.bvalid && !bready);
    if (arvalid && !s.rvalid) begin
      n.rvalid = 1'b1;
      n.rdata  = reg_val(s, araddr);
    end else if (rready) begin
      n.rvalid = 1'b0;
    end
    return n;
  endfunction

  always @(posedge aclk or posedge areset)
    if (areset) m <= '0;
    else        m <= step(m);

  always @(negedge aclk)
    if (!areset) begin
      chk("irq", {31'd0, irq}, {31'd0, m.pend & m.ie});
      chk("bvalid", {31'd0, bvalid}, {31'd0, m.bvalid});
      chk("rvalid", {31'd0, rvalid}, {31'd0, m.rvalid});
      if (m.rvalid) chk("rdata", rdata, m.rdata);
      if (bvalid) chk("bresp", {30'd0, bresp}, 32'd0);
    end

  // ---------------- bus tasks ----------------
  int acc_cyc = 0;

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge aclk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (awready && wready) begin ok = 1'b1; acc_cyc = cyc + 1; break; end
      @(negedge aclk);
    end
    if (!ok) chk("wr_timeout", 32'd0, 32'd1);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge aclk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (arready) begin ok = 1'b1; break; end
      @(negedge aclk);
    end
    if (!ok) chk("rd_timeout", 32'd0, 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    d = rdata;
    chk("rresp", {30'd0, rresp}, 32'd0);
    @(negedge aclk);
    rready = 1'b0;
  endtask

  task automatic wait_irq(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (irq) begin at = cyc; break; end
      @(negedge aclk);
    end
    if (at < 0) chk("irq_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int t1, t2, p;

    #2;
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    repeat (3) @(negedge aclk);
    areset = 1'b0;

    // identity and reset contents
    rd(32'h10, d); chk("clk_freq", d, 32'd100_000_000);
    rd(32'h14, d); chk("version", d, 32'h2024_0100);
    rd(32'h00, d); chk("ctrl_rst", d, 32'd0);
    rd(32'h04, d); chk("stat_rst", d, 32'd0);
    rd(32'h0C, d); chk("count_rst", d, 32'd0);
    rd(32'h18, d); chk("unmapped_rd", d, 32'd0);

    // periodic, PERIOD=9 -> 10 cycles per expiry
    wr(32'h08, 32'd9);
    wr(32'h00, 32'h7);
    wait_irq(40, t1);
    chk("first_expiry", t1 - acc_cyc, 32'd10);
    wr(32'h04, 32'h1);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    wait_irq(40, t2);
    chk("period_gap", t2 - t1, 32'd10);

    // one-shot, PERIOD=4
    wr(32'h00, 32'h0);
    wr(32'h04, 32'h1);
    wr(32'h08, 32'd4);
    wr(32'h00, 32'h3);
    wait_irq(40, t1);
    chk("oneshot_expiry", t1 - acc_cyc, 32'd5);
    rd(32'h00, d); chk("oneshot_ctrl", d, 32'h2);
    rd(32'h0C, d); chk("oneshot_count", d, 32'd0);
    wr(32'h04, 32'h1);
    repeat (20) @(negedge aclk);
    chk("oneshot_no_repeat", {31'd0, irq}, 32'd0);
    rd(32'h04, d); chk("oneshot_pend", d, 32'd0);

    // ie=0: pend without interrupt, then enabling ie raises it at once
    p = $urandom_range(3, 12);
    wr(32'h08, p);
    wr(32'h00, 32'h5);
    repeat (p + 4) @(negedge aclk);
    chk("ie0_irq", {31'd0, irq}, 32'd0);
    rd(32'h04, d); chk("ie0_pend", d, 32'd1);
    wr(32'h00, 32'h7);
    chk("ie1_irq", {31'd0, irq}, 32'd1);

    // PERIOD=0 periodic: expiry every cycle, set beats W1C clear
    wr(32'h00, 32'h0);
    wr(32'h08, 32'd0);
    wr(32'h00, 32'h5);
    wr(32'h04, 32'h1);
    rd(32'h04, d); chk("p0_pend", d, 32'd1);
    wr(32'h00, 32'h0);
    wr(32'h04, 32'h1);

    // random register traffic; the model checks every cycle
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: wr({27'd0, 3'($urandom_range(0, 7)), 2'b00}, 32'($urandom_range(0, 20)));
        1: wr(32'h00, 32'($urandom_range(0, 7)));
        2: rd({27'd0, 3'($urandom_range(0, 7)), 2'b00}, d);
        default: repeat ($urandom_range(0, 25)) @(negedge aclk);
      endcase
    end

    // write response backpressure
    @(negedge aclk);
    awaddr = 32'h08; wdata = 32'd33; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (awready) break;
      @(negedge aclk);
    end
    @(negedge aclk);
    awaddr = 32'h1C;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_bvalid", {31'd0, bvalid}, 32'd1);
      chk("bp_awready", {31'd0, awready}, 32'd0);
      @(negedge aclk);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    rd(32'h08, d); chk("bp_period", d, 32'd33);

    // read data held while rready is low
    @(negedge aclk);
    araddr = 32'h14; arvalid = 1'b1; rready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (arready) break;
      @(negedge aclk);
    end
    @(negedge aclk);
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("rhold_data", rdata, 32'h2024_0100);
      chk("rhold_valid", {31'd0, rvalid}, 32'd1);
    end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;

    // reset while running and mid-read
    wr(32'h08, 32'd50);
    wr(32'h00, 32'h7);
    repeat (5) @(negedge aclk);
    araddr = 32'h0C; arvalid = 1'b1; rready = 1'b0;
    @(negedge aclk);
    arvalid = 1'b0;
    areset = 1'b1;
    #1;
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    rd(32'h00, d); chk("arst_ctrl", d, 32'd0);
    rd(32'h0C, d); chk("arst_count", d, 32'd0);
    rd(32'h08, d); chk("arst_period", d, 32'd0);

    repeat (3) @(negedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
